// File: rtl/lane_slice_reader_pkg.sv
// ---------------------------------------------------------------------------
// lsr_pkg : shared types and helpers for lane_slice_reader.
//   - lsr_state_t : two-state streaming FSM encoding.
//   - default geometry localparams used by the interface and the top.
//   - pos_w()     : width of the signed bit position. It is sized so that
//                   offset +/- count*CHUNK_W can never wrap.
// Configuration macro: LSR_DESCEND_EN (consumed in lane_slice_reader_slice.sv
// and lane_slice_reader.sv).
// ---------------------------------------------------------------------------
package lsr_pkg;

   typedef enum logic [0:0] {
      LSR_IDLE   = 1'b0,
      LSR_STREAM = 1'b1
   } lsr_state_t;

   localparam int LSR_LANES   = 2;
   localparam int LSR_LANE_W  = 32;
   localparam int LSR_CHUNK_W = 8;
   localparam int LSR_OFF_W   = 8;
   localparam int LSR_CNT_W   = 8;

   // One sign bit plus room for offset and count*CHUNK_W.
   function automatic int pos_w(input int off_w, input int cnt_w, input int chunk_w);
      return off_w + cnt_w + $clog2(chunk_w) + 1;
   endfunction

endpackage

// File: rtl/lane_slice_reader_if.sv
// ---------------------------------------------------------------------------
// lane_slice_reader_if : request / slice-stream bundle of lane_slice_reader.
//   Request side : in_valid, in_ready, in_data, in_lane, in_offset, in_count
//   Slice side   : out_valid, out_ready, out_data, out_last, out_err
//   modport master : requester and slice consumer (drives in_*, out_ready)
//   modport slave  : the reader itself
// ---------------------------------------------------------------------------
interface lane_slice_reader_if
   import lsr_pkg::*;
#(
   parameter int LANES   = LSR_LANES,
   parameter int LANE_W  = LSR_LANE_W,
   parameter int CHUNK_W = LSR_CHUNK_W,
   parameter int OFF_W   = LSR_OFF_W,
   parameter int CNT_W   = LSR_CNT_W
);
   logic                                in_valid;
   logic                                in_ready;
   logic [LANES-1:0][LANE_W-1:0]        in_data;
   logic [$clog2(LANES):0]              in_lane;
   logic [OFF_W-1:0]                    in_offset;
   logic [CNT_W-1:0]                    in_count;
   logic                                out_valid;
   logic                                out_ready;
   logic [CHUNK_W-1:0]                  out_data;
   logic                                out_last;
   logic                                out_err;

   modport master (
      output in_valid, in_data, in_lane, in_offset, in_count, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_err
   );

   modport slave (
      input  in_valid, in_data, in_lane, in_offset, in_count, out_ready,
      output in_ready, out_valid, out_data, out_last, out_err
   );
endinterface

// File: rtl/lane_slice_reader_slice.sv
// ---------------------------------------------------------------------------
// lsr_slice : combinational zero-filled slice of one lane word.
//   word_i  : lane word
//   pos_i   : signed bit position
//   slice_o : CHUNK_W-bit slice; bits whose source index falls outside
//             [0, LANE_W) read as 0, so out-of-range reads never produce X.
// Default          : slice_o[k] = word_i[pos_i + k]              (+:)
// LSR_DESCEND_EN   : slice_o[k] = word_i[pos_i - CHUNK_W + 1 + k] (-:)
// ---------------------------------------------------------------------------
module lsr_slice #(
   parameter int LANE_W  = 32,
   parameter int CHUNK_W = 8,
   parameter int POS_W   = 20
) (
   input  logic [LANE_W-1:0]        word_i,
   input  logic signed [POS_W-1:0]  pos_i,
   output logic [CHUNK_W-1:0]       slice_o
);
   localparam int LIDX_W = (LANE_W > 1) ? $clog2(LANE_W) : 1;
   localparam logic signed [POS_W-1:0] ZERO_S   = '0;
   localparam logic signed [POS_W-1:0] LANE_W_S = POS_W'(LANE_W);
`ifdef LSR_DESCEND_EN
   localparam logic signed [POS_W-1:0] BASE_S   = POS_W'(CHUNK_W - 1);
`else
   localparam logic signed [POS_W-1:0] BASE_S   = '0;
`endif

   logic signed [POS_W-1:0] idx_s;

   // Per-bit bounds check against the lane, zero fill outside it.
   always_comb begin
      slice_o = '0;
      idx_s   = '0;
      for (int k = 0; k < CHUNK_W; k++) begin
         idx_s = pos_i - BASE_S + $signed(POS_W'(k));
         if ((idx_s >= ZERO_S) && (idx_s < LANE_W_S)) begin
            slice_o[k] = word_i[idx_s[LIDX_W-1:0]];
         end else begin
            slice_o[k] = 1'b0;
         end
      end
   end
endmodule

// File: rtl/lane_slice_reader.sv
// ---------------------------------------------------------------------------
// lane_slice_reader : streams one lane of a packed [LANES][LANE_W] word as
// in_count CHUNK_W-bit slices starting at a signed bit offset.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : lane_slice_reader_if.slave (request in, slice stream out)
// A request is accepted in IDLE (in_ready=1). The first beat appears the cycle
// after accept. The position advances by CHUNK_W per handshake, and the reader
// returns to IDLE after the last handshake, which leaves one bubble cycle.
// A lane select >= LANES produces all-zero beats with out_err=1.
// Configuration macro: LSR_DESCEND_EN selects -: slicing with a descending
// position.
// ---------------------------------------------------------------------------
module lane_slice_reader
   import lsr_pkg::*;
#(
   parameter int LANES   = LSR_LANES,
   parameter int LANE_W  = LSR_LANE_W,
   parameter int CHUNK_W = LSR_CHUNK_W,
   parameter int OFF_W   = LSR_OFF_W,
   parameter int CNT_W   = LSR_CNT_W
) (
   input logic                clk,
   input logic                rst_n,
   lane_slice_reader_if.slave bus
);
   localparam int POS_W  = pos_w(OFF_W, CNT_W, CHUNK_W);
   localparam int SEL_W  = $clog2(LANES) + 1;
   localparam int LSEL_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic signed [POS_W-1:0] CHUNK_S = POS_W'(CHUNK_W);

   lsr_state_t                state_q;
   logic [LANE_W-1:0]         word_q;
   logic signed [POS_W-1:0]   pos_q;
   logic [CNT_W-1:0]          rem_q;
   logic                      in_ready_q;
   logic                      out_valid_q;
   logic [CHUNK_W-1:0]        out_data_q;
   logic                      out_last_q;
   logic                      out_err_q;

   logic                      sel_oob_d;
   logic [LANE_W-1:0]         sel_word_d;
   logic signed [POS_W-1:0]   pos_nxt_d;
   logic [LANE_W-1:0]         slice_word_d;
   logic signed [POS_W-1:0]   slice_pos_d;
   logic [CHUNK_W-1:0]        beat_data_d;

   // Lane selection at accept; an out-of-range lane becomes an all-zero word.
   always_comb begin
      sel_oob_d  = (bus.in_lane >= SEL_W'(LANES));
      sel_word_d = '0;
      if (sel_oob_d) begin
         sel_word_d = '0;
      end else begin
         sel_word_d = bus.in_data[bus.in_lane[LSEL_W-1:0]];
      end
   end

   // Position of the beat after the current one.
`ifdef LSR_DESCEND_EN
   assign pos_nxt_d = pos_q - CHUNK_S;
`else
   assign pos_nxt_d = pos_q + CHUNK_S;
`endif

   // The slicer serves the first beat (live request) or the following beat
   // (captured word, advanced position) so every beat can be registered.
   always_comb begin
      slice_word_d = '0;
      slice_pos_d  = '0;
      if (state_q == LSR_IDLE) begin
         slice_word_d = sel_word_d;
         slice_pos_d  = POS_W'($signed(bus.in_offset));
      end else begin
         slice_word_d = word_q;
         slice_pos_d  = pos_nxt_d;
      end
   end

   lsr_slice #(
      .LANE_W  (LANE_W),
      .CHUNK_W (CHUNK_W),
      .POS_W   (POS_W)
   ) u_slice (
      .word_i  (slice_word_d),
      .pos_i   (slice_pos_d),
      .slice_o (beat_data_d)
   );

   // Streaming FSM with capture, remaining-beat counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LSR_IDLE;
         word_q      <= '0;
         pos_q       <= '0;
         rem_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_err_q   <= 1'b0;
      end else begin
         case (state_q)
            LSR_IDLE: begin
               in_ready_q <= 1'b1;
               // A zero-count request is consumed without leaving IDLE.
               if (bus.in_valid && in_ready_q && (bus.in_count != '0)) begin
                  state_q     <= LSR_STREAM;
                  word_q      <= sel_word_d;
                  pos_q       <= slice_pos_d;
                  rem_q       <= bus.in_count;
                  in_ready_q  <= 1'b0;
                  out_valid_q <= 1'b1;
                  out_data_q  <= beat_data_d;
                  out_last_q  <= (bus.in_count == CNT_W'(1));
                  out_err_q   <= sel_oob_d;
               end else begin
                  state_q <= LSR_IDLE;
               end
            end
            LSR_STREAM: begin
               if (out_valid_q && bus.out_ready) begin
                  if (rem_q == CNT_W'(1)) begin
                     state_q     <= LSR_IDLE;
                     in_ready_q  <= 1'b1;
                     out_valid_q <= 1'b0;
                     out_data_q  <= '0;
                     out_last_q  <= 1'b0;
                     out_err_q   <= 1'b0;
                  end else begin
                     pos_q      <= pos_nxt_d;
                     rem_q      <= rem_q - CNT_W'(1);
                     out_data_q <= beat_data_d;
                     out_last_q <= (rem_q == CNT_W'(2));
                  end
               end else begin
                  state_q <= LSR_STREAM;
               end
            end
            default: begin
               state_q     <= LSR_IDLE;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               out_data_q  <= '0;
               out_last_q  <= 1'b0;
               out_err_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_err   = out_err_q;
endmodule
